// File: rtl/mips_pkg.sv
// Shared widths and the write-request record used on the register file write port.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     val;
  } wb_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with first-word-fall-through head and per-entry tag/valid taps.
module sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_LSB = 0,
  parameter int TAG_W   = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [WIDTH-1:0]                   din,
  output logic [WIDTH-1:0]                   dout,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0]                   valid,
  output logic [DEPTH-1:0][TAG_W-1:0]        tags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset: validity is defined purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] offset;
    assign offset    = PTR_W'(gi) - rd_ptr_reg;
    assign valid[gi] = (CNT_W'(offset) < count_reg);
    assign tags[gi]  = mem[gi][TAG_LSB +: TAG_W];
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges in-order WB writes and queued long-latency results onto the single
// register file write port, forcing a one-cycle hold when the queue starves.
module wb_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WB_En,
  input  logic [REG_ADDR_W-1:0] WB_Dest,
  input  logic [DATA_W-1:0]     WB_Val,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_dest,
  input  logic [DATA_W-1:0]     lu_val,
  output logic                  lu_ready,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [DATA_W-1:0]     Write_Val,
  output logic                  Write_En,
  output logic                  stall_req,
  output logic [NUM_REGS-1:0]   busy_mask
);

  localparam int ENTRY_W  = REG_ADDR_W + DATA_W;
  localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

  logic                               fifo_full;
  logic                               fifo_empty;
  logic [$clog2(DEPTH):0]             fifo_count;
  logic [DEPTH-1:0]                   fifo_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   fifo_tags;
  logic [ENTRY_W-1:0]                 fifo_head;
  logic                               pipe_req;
  logic                               enq;
  logic                               pop;
  logic                               starve_inc;

  wb_req_t              out_reg, out_next;
  logic                 stall_reg, stall_next;
  logic [STARVE_W-1:0]  starve_reg, starve_next;

  assign pipe_req   = WB_En && (WB_Dest != '0);
  assign lu_ready   = !fifo_full;
  // Dest-0 offers still complete the handshake; they are simply not stored.
  assign enq        = lu_valid && lu_ready && (lu_dest != '0);
  assign pop        = !fifo_empty && (stall_reg || !pipe_req);
  assign starve_inc = !fifo_empty && pipe_req && !stall_reg;

  sync_fifo #(
    .WIDTH   (ENTRY_W),
    .DEPTH   (DEPTH),
    .TAG_LSB (DATA_W),
    .TAG_W   (REG_ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (enq),
    .pop   (pop),
    .din   ({lu_dest, lu_val}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .valid (fifo_valid),
    .tags  (fifo_tags)
  );

  always_comb begin
    out_next    = out_reg;
    out_next.en = 1'b0;
    if (stall_reg) begin
      // WB input is dropped here; upstream holds and re-presents it.
      if (!fifo_empty) out_next = '{en: 1'b1, dest: fifo_head[ENTRY_W-1 -: REG_ADDR_W], val: fifo_head[DATA_W-1:0]};
    end else if (pipe_req) begin
      out_next = '{en: 1'b1, dest: WB_Dest, val: WB_Val};
    end else if (!fifo_empty) begin
      out_next = '{en: 1'b1, dest: fifo_head[ENTRY_W-1 -: REG_ADDR_W], val: fifo_head[DATA_W-1:0]};
    end
  end

  always_comb begin
    starve_next = starve_reg;
    stall_next  = 1'b0;
    if (fifo_count == '0 || pop) begin
      starve_next = '0;
    end else if (starve_inc) begin
      if (starve_reg == STARVE_W'(STARVE_LIMIT - 1)) begin
        stall_next  = 1'b1;
        starve_next = '0;
      end else begin
        starve_next = starve_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg    <= '0;
      stall_reg  <= 1'b0;
      starve_reg <= '0;
    end else begin
      out_reg    <= out_next;
      stall_reg  <= stall_next;
      starve_reg <= starve_next;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) busy_mask[fifo_tags[i]] = 1'b1;
    end
  end

  assign dest      = out_reg.dest;
  assign Write_Val = out_reg.val;
  assign Write_En  = out_reg.en;
  assign stall_req = stall_reg;

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Single transmitter onto the register file's one write port; drives `dest` / `Write_Val` / `Write_En`.
- Merges two write sources: the in-order WB stage, and results from a long-latency unit (mul/div), which are held in a small FIFO.
- In-order WB writes have priority. Queued results drain in idle WB slots. A starvation counter forces a drain by requesting a one-cycle pipeline hold.

Parameters:
- DEPTH, 4, FIFO entries for long-latency results (power of 2, ≥2).
- STARVE_LIMIT, 8, consecutive blocked cycles with a non-empty FIFO before `stall_req` is raised.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- WB_En  in  1  WB stage has a result this cycle.
- WB_Dest  in  5  WB destination register.
- WB_Val  in  32  WB result.
- lu_valid  in  1  long-latency unit offers a result.
- lu_dest  in  5  its destination.
- lu_val  in  32  its value.
- lu_ready  out  1  FIFO accepts this cycle; equals !full from registered count.
- dest  out  5  register file write address (registered).
- Write_Val  out  32  register file write data (registered).
- Write_En  out  1  register file write enable (registered).
- stall_req  out  1  pipeline must hold its MEM/WB stage this cycle (registered).
- busy_mask  out  32  bit r set iff a valid FIFO entry targets r (combinational from FIFO state).

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFO emptied; count=0; starvation counter=0.
  - Outputs `dest`=0, `Write_Val`=0, `Write_En`=0, `stall_req`=0.
  - `lu_ready`=1 and `busy_mask`=0 afterwards.
  - Reset mid-operation discards queued results without writing them.
- Definitions (per cycle):
  - pipe_req = WB_En && WB_Dest!=0.
  - enq = lu_valid && lu_ready && lu_dest!=0.
  - lu_valid with lu_dest==0 is handshaken (ready honoured) and dropped.
- Selection at each posedge, registered outputs:
  - stall_req==1: pop FIFO head (non-empty guaranteed); output {head dest, head val, 1}. The WB input this cycle is ignored; upstream re-presents it next cycle.
  - else pipe_req: output {WB_Dest, WB_Val, 1}.
  - else FIFO non-empty: pop head; output {head dest, head val, 1}.
  - else: `Write_En`=0; `dest` and `Write_Val` hold their previous values.
- Latency:
  - Exactly 1 cycle from input to `Write_En`.
  - The register file captures on the following negedge, so a value is visible to readers in the half-cycle after that.
- FIFO:
  - Circular buffer with log2(DEPTH) pointers; wrap-around at DEPTH.
  - Enqueue and dequeue in the same cycle: count unchanged, both pointers advance.
  - Enqueue blocked when full, even if a pop occurs that cycle (`lu_ready` is computed from the registered count).
  - Order strictly FIFO.
- Starvation counter:
  - Increments when FIFO non-empty && pipe_req && !stall_req.
  - Clears when FIFO empty or a FIFO pop occurs.
  - `stall_req` is set for exactly one cycle when the counter reaches STARVE_LIMIT-1 and increments; the counter then clears.
  - `stall_req` never asserts two cycles in a row.
- WAW ordering:
  - The arbiter does not reorder by register.
  - The hazard unit must use `busy_mask` and must not issue an instruction whose destination has its bit set.
  - Consequence: a pipeline write never targets a queued dest.
- Register 0: never written (Write_En stays 0 for dest 0 from either source).

Decomposition:
- Shared package `mips_pkg`: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and typedef wb_req_t {en, dest, val}.
- One sub-module: `sync_fifo` (parameterised width/depth; push/pop/full/empty/count; exposes all entries plus valid bits for `busy_mask`).

Test Plan:
- Reset → `Write_En`=0, `dest`=0, `Write_Val`=0, `stall_req`=0, `lu_ready`=1, `busy_mask`=0; repeat reset while 3 entries are queued → queue cleared, no writes emitted.
- WB_En=1, WB_Dest=5, WB_Val=0xDEADBEEF, no lu → next cycle `Write_En`=1, `dest`=5, `Write_Val`=0xDEADBEEF; WB_Dest=0 → `Write_En`=0.
- lu pushes (7,0x11),(9,0x22) while WB idle → writes to 7 then 9 on consecutive cycles; `busy_mask` bits 7 and 9 set while queued, then clear.
- WB_En=1 continuously, lu pushes dest 3 → `stall_req`=1 in cycle STARVE_LIMIT; the following cycle writes r3 and ignores the WB input; the held WB write emits next.
- Fill FIFO to DEPTH=4 with WB busy → `lu_ready`=0; a push attempted that cycle is not accepted; after one pop `lu_ready`=1; pointer wrap keeps FIFO order.
- Simultaneous enqueue and dequeue at count=2 → count stays 2; lu_dest=0 push → accepted, never written, `busy_mask` unchanged.
